// File: rtl/max_group_drain.sv
// Drains every maximal element of a sort pass, lowest index first, over valid/ready,
// then publishes the remaining active-element mask for the next pass.
module max_group_drain #(
    parameter int M     = 8,
    parameter int N     = 16,
    parameter int IDX_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [M-1:0][N-1:0] i_chi,
    input  logic [M-1:0]        i_h_matrix,
    input  logic [M-1:0]        i_active,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [N-1:0]        o_data,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_valid,
    output logic                o_last,
    input  logic                i_ready,
    output logic                o_done,
    output logic [M-1:0]        o_active_next,
    output logic                o_empty
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state;
    logic [M-1:0][N-1:0] chi_r;
    logic [M-1:0]        pend;
    logic [M-1:0]        act_nxt;
    logic [M-1:0]        active_next_r;
    logic                empty_r;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_last;
    logic [M-1:0]        acc_pend;

    // Scan from the top so the lowest set bit is the one left standing.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [M-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int q = M - 1; q >= 0; q--) begin
            if (v[q]) r = IDX_W'(q);
        end
        return r;
    endfunction

    function automatic logic single_bit(input logic [M-1:0] v);
        return (v != '0) && ((v & (v - M'(1))) == '0);
    endfunction

    assign acc_pend = i_h_matrix & i_active;
    assign cur_idx  = lowest_idx(pend);
    assign cur_last = single_bit(pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pend          <= '0;
            chi_r         <= '0;
            act_nxt       <= '0;
            active_next_r <= '0;
            empty_r       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        chi_r   <= i_chi;
                        pend    <= acc_pend;
                        act_nxt <= i_active & ~acc_pend;
                        if (acc_pend != '0) begin
                            state <= S_DRAIN;
                        end else begin
                            // Empty group: the remaining mask is published on DONE entry.
                            state         <= S_DONE;
                            active_next_r <= i_active;
                            empty_r       <= (i_active == '0);
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_ready) begin
                        pend <= pend & ~(M'(1) << cur_idx);
                        if (cur_last) begin
                            state         <= S_DONE;
                            active_next_r <= act_nxt;
                            empty_r       <= (act_nxt == '0);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_ready       = (state == S_IDLE);
    assign o_valid       = (state == S_DRAIN);
    assign o_done        = (state == S_DONE);
    assign o_idx         = cur_idx;
    assign o_data        = chi_r[cur_idx];
    assign o_last        = o_valid & cur_last;
    assign o_active_next = active_next_r;
    assign o_empty       = empty_r;

endmodule
